// File: rtl/rv32m_div_unit.sv
// Iterative RV32M divide unit (DIV, DIVU, REM, REMU).
// One operation in flight: a 32-step restoring divider on operand magnitudes,
// with sign correction on the last step. Divide-by-zero and signed overflow
// are resolved at accept and skip the iteration entirely.

module rv32m_div_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_func3,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [XLEN-1:0] MinInt  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [4:0]      LastCnt = 5'd31;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0]  quot_q, quot_d;       // dividend bits shift out, quotient bits shift in
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  divisor_q, divisor_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic             want_rem_q, want_rem_d;
    logic             out_valid_q, out_valid_d;

    // Operand decode at the issue boundary.
    logic            is_unsigned;
    logic            want_rem;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] rs1_abs;
    logic [XLEN-1:0] rs2_abs;
    logic            div_by_zero;
    logic            overflow;
    logic [XLEN-1:0] special_result;
    logic            unused_func3;

    assign is_unsigned  = in_func3[0];
    assign want_rem     = in_func3[1];
    assign unused_func3 = in_func3[2];
    assign rs1_neg      = ~is_unsigned & in_rs1[XLEN-1];
    assign rs2_neg      = ~is_unsigned & in_rs2[XLEN-1];
    assign rs1_abs      = rs1_neg ? -in_rs1 : in_rs1;
    assign rs2_abs      = rs2_neg ? -in_rs2 : in_rs2;
    assign div_by_zero  = (in_rs2 == '0);
    assign overflow     = ~is_unsigned & (in_rs1 == MinInt) & (in_rs2 == '1);

    // Divide by zero: quotient all ones, remainder is the raw dividend.
    // Overflow: quotient is the dividend (MinInt), remainder zero.
    assign special_result = div_by_zero ? (want_rem ? in_rs1 : '1)
                                        : (want_rem ? '0 : MinInt);

    // One restoring step. Since rem < divisor, the shifted value is below
    // 2*divisor, so bit XLEN of the difference is set exactly on a borrow.
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            step_ok;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quot_step;
    logic [XLEN-1:0] quot_fin;
    logic [XLEN-1:0] rem_fin;

    assign shifted   = {rem_q, quot_q[XLEN-1]};
    assign diff      = shifted - {1'b0, divisor_q};
    assign step_ok   = ~diff[XLEN];
    assign rem_step  = step_ok ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quot_step = {quot_q[XLEN-2:0], step_ok};
    assign quot_fin  = neg_quot_q ? -quot_step : quot_step;
    assign rem_fin   = neg_rem_q ? -rem_step : rem_step;

    // Acceptance depends only on state and reset.
    assign in_ready   = (state_q == StIdle) & ~rst;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign out_tag    = tag_q;

    // Next-state and datapath update; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        divisor_d   = divisor_q;
        result_d    = result_q;
        tag_d       = tag_q;
        cnt_d       = cnt_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
        want_rem_d  = want_rem_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && !flush) begin
                    tag_d = in_tag;
                    if (div_by_zero || overflow) begin
                        result_d    = special_result;
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        quot_d     = rs1_abs;
                        rem_d      = '0;
                        divisor_d  = rs2_abs;
                        neg_quot_d = rs1_neg ^ rs2_neg;
                        neg_rem_d  = rs1_neg;
                        want_rem_d = want_rem;
                        cnt_d      = '0;
                        state_d    = StBusy;
                    end
                end
            end
            StBusy: begin
                quot_d = quot_step;
                rem_d  = rem_step;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == LastCnt) begin
                    result_d    = want_rem_q ? rem_fin : quot_fin;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = StIdle;
            end
        endcase

        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            quot_q      <= '0;
            rem_q       <= '0;
            divisor_q   <= '0;
            result_q    <= '0;
            tag_q       <= '0;
            cnt_q       <= '0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            want_rem_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            divisor_q   <= divisor_d;
            result_q    <= result_d;
            tag_q       <= tag_d;
            cnt_q       <= cnt_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
            want_rem_q  <= want_rem_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_rv32m_div_unit.sv
// Directed bench for rv32m_div_unit: results, tags, latency, backpressure,
// flush and mid-operation reset against hand-computed values.

module tb_rv32m_div_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 6;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_func3;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    int err_cnt = 0;
    int chk_cnt = 0;

    rv32m_div_unit #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_func3   (in_func3),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Advance one clock; all driving and sampling happens 1ns after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] tag);
        check_eq($sformatf("%s in_ready", name), {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_func3 = f3;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        tick();
        in_valid = 1'b0;
    endtask

    // Latency counted in cycles after the accept cycle; 1 = the very next cycle.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] tag,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(name, f3, a, b, tag);
        wait_valid(lat);
        check_eq($sformatf("%s latency", name), lat, exp_lat);
        check_eq($sformatf("%s result", name), out_result, exp);
        check_eq($sformatf("%s tag", name), {26'd0, out_tag}, {26'd0, tag});
        tick();
        check_eq($sformatf("%s valid_drop", name), {31'd0, out_valid}, 32'd0);
        check_eq($sformatf("%s back_idle", name), {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_func3  = F_DIV;
        in_rs1    = '0;
        in_rs2    = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check_eq("reset in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("reset out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("reset out_result", out_result, 32'd0);
        check_eq("reset out_tag", {26'd0, out_tag}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post-reset in_ready", {31'd0, in_ready}, 32'd1);

        // Signed and unsigned divide/remainder.
        run_op("DIV -7/2",     F_DIV,  32'hFFFF_FFF9, 32'd2, 6'd5, 32'hFFFF_FFFD, 33);
        run_op("REM -7/2",     F_REM,  32'hFFFF_FFF9, 32'd2, 6'd6, 32'hFFFF_FFFF, 33);
        run_op("DIVU max/1",   F_DIVU, 32'hFFFF_FFFF, 32'd1, 6'd7, 32'hFFFF_FFFF, 33);
        run_op("REMU 100/7",   F_REMU, 32'd100, 32'd7, 6'd8, 32'd2, 33);
        run_op("DIVU 7/100",   F_DIVU, 32'd7, 32'd100, 6'd10, 32'd0, 33);
        run_op("REM 100/-3",   F_REM,  32'd100, 32'hFFFF_FFFD, 6'd11, 32'd1, 33);
        run_op("DIV -100/-3",  F_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFFD, 6'd14, 32'd33, 33);
        run_op("REM -100/-3",  F_REM,  32'hFFFF_FF9C, 32'hFFFF_FFFD, 6'd15, 32'hFFFF_FFFF, 33);

        // Special cases resolve at accept.
        run_op("DIV 5/0",      F_DIV,  32'd5, 32'd0, 6'd16, 32'hFFFF_FFFF, 1);
        run_op("REMU 5/0",     F_REMU, 32'd5, 32'd0, 6'd17, 32'd5, 1);
        run_op("DIV ovf",      F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 6'd18, 32'h8000_0000, 1);
        run_op("REM ovf",      F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 6'd19, 32'd0, 1);
        run_op("DIVU no-ovf",  F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 6'd21, 32'd0, 33);

        // Backpressure: hold the result for 10 cycles while issue keeps pushing.
        out_ready = 1'b0;
        issue("BP", F_DIVU, 32'd100, 32'd7, 6'd9);
        wait_valid(lat);
        check_eq("BP latency", lat, 33);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_func3 = F_DIV;
            in_rs1   = 32'd5;
            in_rs2   = 32'd0;
            in_tag   = 6'd31;
            tick();
            check_eq($sformatf("BP hold%0d valid", i), {31'd0, out_valid}, 32'd1);
            check_eq($sformatf("BP hold%0d result", i), out_result, 32'd14);
            check_eq($sformatf("BP hold%0d tag", i), {26'd0, out_tag}, 32'd9);
            check_eq($sformatf("BP hold%0d in_ready", i), {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_eq("BP release valid", {31'd0, out_valid}, 32'd0);
        check_eq("BP release in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check_eq("BP no stale accept", {31'd0, out_valid}, 32'd0);

        // Flush together with in_valid in IDLE accepts nothing.
        in_valid = 1'b1;
        flush    = 1'b1;
        in_func3 = F_DIV;
        in_rs1   = 32'd5;
        in_rs2   = 32'd0;
        in_tag   = 6'd30;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check_eq("flush idle valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush idle in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check_eq("flush idle no result", {31'd0, out_valid}, 32'd0);

        // Flush in BUSY cycle 10, then issue straight away.
        issue("FL", F_DIV, 32'd1000, 32'd3, 6'd12);
        repeat (9) tick();
        flush = 1'b1;
        check_eq("FL busy valid", {31'd0, out_valid}, 32'd0);
        tick();
        flush = 1'b0;
        check_eq("FL in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("FL valid", {31'd0, out_valid}, 32'd0);
        run_op("DIV 100/-3",   F_DIV,  32'd100, 32'hFFFF_FFFD, 6'd13, 32'hFFFF_FFDF, 33);

        // One-cycle reset in the middle of BUSY.
        issue("RST", F_DIV, 32'd1000, 32'd3, 6'd20);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check_eq("mid-rst in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("mid-rst out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid-rst out_result", out_result, 32'd0);
        check_eq("mid-rst out_tag", {26'd0, out_tag}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post mid-rst in_ready", {31'd0, in_ready}, 32'd1);
        run_op("DIV 1000/3",   F_DIV,  32'd1000, 32'd3, 6'd22, 32'd333, 33);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
